// File: rtl/wb_slave_responder_if.sv
// Wishbone bus bundle between a master and wb_slave_responder.
// err_o exists only when WB_SLAVE_RESPONDER_ERR_EN is defined.
interface wb_slave_responder_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic                  cyc_i;
    logic                  stb_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;
    logic                  irq_o;
`ifdef WB_SLAVE_RESPONDER_ERR_EN
    logic                  err_o;

    modport master (output cyc_i, stb_i, adr_i, we_i, dat_i,
                    input  dat_o, ack_o, irq_o, err_o);
    modport slave  (input  cyc_i, stb_i, adr_i, we_i, dat_i,
                    output dat_o, ack_o, irq_o, err_o);
`else
    modport master (output cyc_i, stb_i, adr_i, we_i, dat_i,
                    input  dat_o, ack_o, irq_o);
    modport slave  (input  cyc_i, stb_i, adr_i, we_i, dat_i,
                    output dat_o, ack_o, irq_o);
`endif
endinterface

// File: rtl/wb_slave_responder.sv
// Wishbone slave with a small register bank, programmable wait states and a doorbell irq.
// Optional WB_SLAVE_RESPONDER_ERR_EN: out-of-range accesses end with err_o instead of ack_o.
module wb_slave_responder #(
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = 3,
    parameter int WAIT_STATES = 1,
    parameter int IRQ_ADDR    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wb_slave_responder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  ack_q, ack_d;
    logic                  irq_q, irq_d;
    logic                  irq_set_q, irq_set_d;
    logic                  irq_clr_q, irq_clr_d;
`ifdef WB_SLAVE_RESPONDER_ERR_EN
    logic                  err_q, err_d;
`endif

    logic                  req;
    logic                  commit;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_data;

    assign req      = bus.cyc_i & bus.stb_i;
    assign in_range = int'(bus.adr_i) < NUM_REGS;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (int'(bus.adr_i) == i) rd_data = regs_q[i];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        regs_d    = regs_q;
        dat_d     = '0;
        ack_d     = 1'b0;
        irq_set_d = 1'b0;
        irq_clr_d = 1'b0;
        irq_d     = irq_q;
        commit    = 1'b0;
`ifdef WB_SLAVE_RESPONDER_ERR_EN
        err_d     = 1'b0;
`endif
        // irq follows the commit by one edge, i.e. it moves as ack_o drops
        if (irq_set_q) irq_d = 1'b1;
        if (irq_clr_q) irq_d = 1'b0;

        case (state_q)
            S_IDLE: if (req) begin
                if (WAIT_STATES == 0) begin
                    commit  = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d   = 4'(WAIT_STATES - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            ack_d = 1'b1;
`ifdef WB_SLAVE_RESPONDER_ERR_EN
            if (!in_range) begin
                ack_d = 1'b0;
                err_d = 1'b1;
            end
`endif
            if (in_range && bus.we_i) begin
                for (int i = 0; i < NUM_REGS; i++)
                    if (int'(bus.adr_i) == i) regs_d[i] = bus.dat_i;
                if (int'(bus.adr_i) == IRQ_ADDR) irq_set_d = 1'b1;
            end else if (in_range) begin
                dat_d = rd_data;
                if (int'(bus.adr_i) == IRQ_ADDR) irq_clr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            irq_q     <= 1'b0;
            irq_set_q <= 1'b0;
            irq_clr_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef WB_SLAVE_RESPONDER_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            irq_q     <= irq_d;
            irq_set_q <= irq_set_d;
            irq_clr_q <= irq_clr_d;
            regs_q    <= regs_d;
`ifdef WB_SLAVE_RESPONDER_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    assign bus.dat_o = dat_q;
    assign bus.ack_o = ack_q;
    assign bus.irq_o = irq_q;
`ifdef WB_SLAVE_RESPONDER_ERR_EN
    assign bus.err_o = err_q;
`endif

endmodule
